program_loader: RTL
===================

Name: program_loader

Overview:
- Front-end loader that fills the CPU RAM's program-entry port (input_mode / input_address / input_program) from a byte stream with a valid/ready handshake.
- Holds the CPU in reset while it loads.
- Verifies a frame checksum and releases the CPU only when the checksum passes.
- Sits directly upstream of the RAM and ControlSequencer, and replaces hand-driven program entry.

Parameters:
- ADDR_W, 4, RAM address width; the memory depth is 2^ADDR_W.
- DATA_W, 8, instruction/data byte width.
- TIMEOUT, 255, maximum number of idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins frame reception; honoured only in IDLE or DONE.
- byte_in  in  DATA_W  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  the loader accepts byte_in this cycle; a transfer occurs when byte_valid & byte_ready are both high at a clock edge.
- input_mode  out  1  high while the RAM is in program-entry mode.
- input_address  out  ADDR_W  RAM write address.
- input_program  out  DATA_W  RAM write data.
- prog_we  out  1  one-cycle write strobe; RAM captures input_address/input_program while it is high.
- cpu_reset  out  1  active-low reset to the CPU datapath; low means the CPU is held.
- done  out  1  frame loaded and verified.
- error  out  1  checksum failure or timeout on the last frame.

Behaviour:
- Reset (asynchronous, reset=0) puts the block in IDLE with these output values:
  - byte_ready=0, input_mode=0, input_address=0, input_program=0, prog_we=0
  - cpu_reset=0, done=0, error=0
  - checksum accumulator, length counter and timeout counter all 0
- Reset may assert in any state. A frame interrupted by reset is discarded, and words already written stay in RAM.
- Frame format:
  - HDR byte: [7:4] = start address, [3:0] = length-1, giving 1..16 data bytes.
  - Then length DATA bytes.
  - Then one CSUM byte, chosen so that the 8-bit modulo-256 sum of HDR + all DATA + CSUM equals 0x00.
- States:
  - IDLE:
    - byte_ready=0.
    - start -> HDR; clears error and done, drives cpu_reset=0 and input_mode=1.
  - HDR:
    - byte_ready=1.
    - On transfer: address register = byte[7:4], remaining = byte[3:0]+1, checksum = byte, go to DATA.
  - DATA:
    - byte_ready=1.
    - On transfer: input_program <= byte, input_address <= address register, checksum += byte, go to WRITE.
  - WRITE:
    - Lasts exactly one cycle, with byte_ready=0 and prog_we=1.
    - Address register increments modulo 2^ADDR_W, so 15 wraps to 0. remaining decrements.
    - Next state: DATA if remaining != 0, otherwise CSUM.
  - CSUM:
    - byte_ready=1.
    - On transfer, if checksum + byte == 0x00 -> DONE; otherwise -> IDLE with error=1.
  - DONE:
    - input_mode=0 and done=1.
    - cpu_reset goes high on the edge that enters DONE and stays high.
    - start -> HDR: cpu_reset=0, done=0, input_mode=1 on the next edge.
- Throughput: at most one data byte every 2 cycles. Header and checksum bytes take 1 cycle each.
- Write latency: prog_we is asserted in the cycle immediately after the data transfer edge. input_address and input_program are stable for that whole cycle.
- start while in HDR, DATA, WRITE or CSUM is ignored.
- byte_valid outside HDR, DATA or CSUM is ignored, and no transfer occurs.
- Timeout:
  - The counter clears on every transfer and on entry to HDR, and increments each cycle in HDR, DATA or CSUM when no transfer occurs.
  - Reaching TIMEOUT -> IDLE with error=1, cpu_reset=0, input_mode=0.
- error is held until the next start or reset.
- cpu_reset is never high while input_mode=1.
- Simultaneous start and byte_valid in IDLE: start is taken and the byte is not consumed, because byte_ready=0.

Test Plan:
- Basic load: reset pulse, then start, then bytes 0x02, 0x79, 0x30, 0x7A, 0xDB with byte_valid held high.
  - Required: prog_we pulses write 0x79@0, 0x30@1, 0x7A@2.
  - Required: done=1, error=0, cpu_reset rises on the edge after CSUM, input_mode=0.
- Wrap-around: start, then 0xE2, 0x11, 0x22, 0x33, 0xB8.
  - Required: writes 0x11@14, 0x22@15, 0x33@0; done=1.
- Bad checksum: the basic frame with CSUM=0x00.
  - Required: all three writes occur, then error=1, done=0, cpu_reset stays 0, state returns to IDLE with byte_ready=0.
- Back-pressure and timeout:
  - With byte_valid toggled every other cycle, the basic frame loads correctly.
  - Stopping after HDR 0x02 for TIMEOUT cycles gives error=1 and no further prog_we.
- Reset mid-load: assert reset low after the second data byte.
  - Required: all outputs return to reset values immediately, without waiting for clk.
  - After release, a fresh basic frame loads to done=1.
- Reload: from DONE, pulse start and send 0x30, 0x55, 0x7B.
  - Required: cpu_reset drops on the next edge, 0x55 is written at address 3, then done=1 and cpu_reset=1.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: parses HDR/DATA/CSUM frames into RAM program-entry
// writes, holds the CPU in reset while loading and releases it on a good checksum.
module program_loader #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              input_mode,
  output logic [ADDR_W-1:0] input_address,
  output logic [DATA_W-1:0] input_program,
  output logic              prog_we,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned LEN_W = DATA_W - ADDR_W;
  localparam int unsigned REM_W = LEN_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                byte_ready_q, byte_ready_d;
  logic                input_mode_q, input_mode_d;
  logic [ADDR_W-1:0]   input_address_q, input_address_d;
  logic [DATA_W-1:0]   input_program_q, input_program_d;
  logic                prog_we_q, prog_we_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                xfer;
  logic                busy;
  logic [DATA_W-1:0]   sum_c;

  assign xfer  = byte_valid & byte_ready_q;
  assign busy  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign sum_c = csum_q + byte_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      csum_q          <= '0;
      tmo_q           <= '0;
      byte_ready_q    <= 1'b0;
      input_mode_q    <= 1'b0;
      input_address_q <= '0;
      input_program_q <= '0;
      prog_we_q       <= 1'b0;
      cpu_reset_q     <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      csum_q          <= csum_d;
      tmo_q           <= tmo_d;
      byte_ready_q    <= byte_ready_d;
      input_mode_q    <= input_mode_d;
      input_address_q <= input_address_d;
      input_program_q <= input_program_d;
      prog_we_q       <= prog_we_d;
      cpu_reset_q     <= cpu_reset_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    csum_d          = csum_q;
    tmo_d           = tmo_q;
    input_mode_d    = input_mode_q;
    input_address_d = input_address_q;
    input_program_d = input_program_q;
    prog_we_d       = 1'b0;
    cpu_reset_d     = cpu_reset_q;
    done_d          = done_q;
    error_d         = error_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_HDR;
          error_d      = 1'b0;
          done_d       = 1'b0;
          cpu_reset_d  = 1'b0;
          input_mode_d = 1'b1;
          tmo_d        = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          addr_d  = byte_in[DATA_W-1:LEN_W];
          rem_d   = REM_W'(byte_in[LEN_W-1:0]) + REM_W'(1);
          csum_d  = byte_in;
          tmo_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          input_program_d = byte_in;
          input_address_d = addr_q;
          csum_d          = sum_c;
          tmo_d           = '0;
          prog_we_d       = 1'b1;
          state_d         = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - REM_W'(1);
        state_d = (rem_q != REM_W'(1)) ? S_DATA : S_CSUM;
      end
      S_CSUM: begin
        if (xfer) begin
          tmo_d        = '0;
          input_mode_d = 1'b0;
          if (sum_c == '0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle gap inside a frame: abort once the gap reaches TIMEOUT cycles.
    if (busy && !xfer) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == TMO_W'(TIMEOUT)) begin
        tmo_d        = '0;
        state_d      = S_IDLE;
        error_d      = 1'b1;
        cpu_reset_d  = 1'b0;
        input_mode_d = 1'b0;
      end
    end

    byte_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  assign byte_ready    = byte_ready_q;
  assign input_mode    = input_mode_q;
  assign input_address = input_address_q;
  assign input_program = input_program_q;
  assign prog_we       = prog_we_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
